deser_stage: RTL and testbench
==============================

DESER_STAGE -- requirements
Module: deser_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the assembled word width in bits (>= 2).
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the number of output buffer entries (power of two, >= 2).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port IN_valid, input, 1 bit: a serial bit is offered this cycle.
REQ-006 Port IN_bit, input, 1 bit: the serial data bit.
REQ-007 Port OUT_inReady, output, 1 bit: the block accepts the offered bit this cycle.
REQ-008 Port IN_clear, input, 1 bit: synchronous discard of the partially assembled word.
REQ-009 Port IN_ready, input, 1 bit: the downstream stage accepts a word this cycle.
REQ-010 Port OUT_valid, output, 1 bit: OUT_data holds a valid word.
REQ-011 Port OUT_data, output, WIDTH bits: the assembled word, which feeds the per-bit lane stage downstream.
REQ-012 Port OUT_count, output, $clog2(WIDTH) bits: the number of bits collected in the current partial word.

Function
REQ-013 A bit SHALL be accepted on an edge where IN_valid && OUT_inReady && !IN_clear.
REQ-014 Accepted bits SHALL be assembled LSB-first: the k-th accepted bit of a word (k = 0..WIDTH-1) lands in bit k.
REQ-015 A bit counter SHALL track the position; it SHALL increment by 1 per accepted bit and wrap from WIDTH-1 to 0 on the edge that accepts the final bit.
REQ-016 On acceptance of the final bit, the completed word (including that bit) SHALL be pushed into the output buffer on the same edge.
REQ-017 The output buffer SHALL be a DEPTH-entry circular FIFO with read and write pointers that wrap modulo DEPTH.
REQ-018 The output buffer SHALL track occupancy 0..DEPTH so that full and empty are distinguished.
REQ-019 OUT_valid SHALL equal (occupancy != 0).
REQ-020 OUT_data SHALL present the head entry directly from registered storage.
REQ-021 A pop SHALL occur on an edge where OUT_valid && IN_ready.
REQ-022 Latency: if the buffer is empty, OUT_valid SHALL rise in the cycle after the edge that accepted the final bit, with the word on OUT_data.
REQ-023 OUT_inReady SHALL be 1 unless all of the following hold: count == WIDTH-1, buffer full, and IN_ready == 0.
- This gives a combinational path from IN_ready to OUT_inReady.
- Non-final bits are always accepted, even when the buffer is full.
REQ-024 Simultaneous push and pop SHALL both take effect, leaving occupancy unchanged; this is also legal when the buffer is full.
REQ-025 Behaviour of IN_clear:
- It SHALL zero the counter and the partial shift register.
- It SHALL leave the buffer and any pop on the same edge unaffected.
- A bit offered on the same edge SHALL be dropped.
REQ-026 OUT_data and OUT_valid SHALL remain stable while OUT_valid && !IN_ready.
REQ-027 OUT_count SHALL reflect the registered counter value.
REQ-028 Behaviour while IN_valid == 0: IN_bit SHALL be ignored and no state SHALL change except by pop or IN_clear.

Reset
REQ-029 While rst == 0 (asynchronously, including mid-word or mid-handshake), the block SHALL:
- zero the counter, shift register and FIFO pointers;
- set occupancy to 0;
- drive OUT_valid = 0, OUT_count = 0 and OUT_data = 0.
REQ-030 All words buffered or in progress at reset SHALL be lost.
REQ-031 After rst deasserts, the first bit SHALL be accepted on the first rising edge with IN_valid = 1.

Verification
REQ-032 Single word: WIDTH = 8, IN_ready = 1; feed bits 1,0,1,1,0,0,0,1 on consecutive cycles -> OUT_valid = 1 for exactly one cycle, starting the cycle after the 8th bit, with OUT_data = 8'h8D.
REQ-033 Backpressure: IN_ready = 0; stream 3 words 8'hFF, 8'h00, 8'hA5 -> words 1-2 are buffered; OUT_inReady = 0 while count == 7. Then raise IN_ready -> the same cycle the 8th bit of 8'hA5 is accepted, and outputs arrive in order FF, 00, A5.
REQ-034 Full plus simultaneous push/pop: buffer full, IN_ready = 1 and the final bit offered on the same edge -> occupancy stays 2, the head advances, and no word is lost.
REQ-035 Clear: after 5 bits, pulse IN_clear with IN_valid = 1 -> OUT_count = 0 and that bit is dropped; the next 8 bits form a clean word, and buffered words are untouched.
REQ-036 Async reset: assert rst = 0 between clock edges while occupancy = 1 and count = 4 -> OUT_valid = 0, OUT_count = 0 and OUT_data = 0 immediately, without waiting for a clock edge.
REQ-037 Pointer wrap: stream 10 words with random IN_ready (DEPTH = 2) -> the output sequence equals the input sequence, checked against a reference queue.

Source files
------------

// File: rtl/deser_stage.sv
// Serial-to-parallel stage: collects LSB-first bits into WIDTH-bit words and
// queues completed words in a small circular FIFO for the downstream lane stage.
module deser_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IN_valid,
    input  logic                     IN_bit,
    output logic                     OUT_inReady,
    input  logic                     IN_clear,
    input  logic                     IN_ready,
    output logic                     OUT_valid,
    output logic [WIDTH-1:0]         OUT_data,
    output logic [$clog2(WIDTH)-1:0] OUT_count
);
    localparam int CW = $clog2(WIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [CW-1:0]                cnt;
    logic [WIDTH-1:0]             sreg;
    logic [WIDTH-1:0]             word;
    logic [DEPTH-1:0][WIDTH-1:0]  mem;
    logic [PW-1:0]                wr_ptr;
    logic [PW-1:0]                rd_ptr;
    logic [OW-1:0]                occ;

    logic last, full, accept, push, pop;

    assign last   = (cnt == CW'(WIDTH - 1));
    assign full   = (occ == OW'(DEPTH));
    // Only the final bit can stall; a full buffer with a concurrent pop still has room.
    assign OUT_inReady = !(last && full && !IN_ready);
    assign accept = IN_valid && OUT_inReady && !IN_clear;
    assign push   = accept && last;
    assign pop    = OUT_valid && IN_ready;

    assign OUT_valid = (occ != '0);
    assign OUT_data  = mem[rd_ptr];
    assign OUT_count = cnt;

    // Completed word includes the bit being accepted this edge.
    always_comb begin
        word      = sreg;
        word[cnt] = IN_bit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            sreg   <= '0;
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (IN_clear) begin
                cnt  <= '0;
                sreg <= '0;
            end else if (accept) begin
                if (last) begin
                    cnt  <= '0;
                    sreg <= '0;
                end else begin
                    cnt  <= cnt + CW'(1);
                    sreg <= word;
                end
            end

            if (push) begin
                mem[wr_ptr] <= word;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);

            case ({push, pop})
                2'b10:   occ <= occ + OW'(1);
                2'b01:   occ <= occ - OW'(1);
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: tb/tb_deser_stage.sv
// Directed bench for deser_stage (WIDTH=8, DEPTH=2) with a reference queue for
// the pointer-wrap stream.
module tb_deser_stage;
    logic       clk, rst, IN_valid, IN_bit, IN_clear, IN_ready;
    logic       OUT_inReady, OUT_valid;
    logic [7:0] OUT_data;
    logic [2:0] OUT_count;

    int checks = 0;
    int failures = 0;

    deser_stage #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .IN_valid(IN_valid), .IN_bit(IN_bit),
        .OUT_inReady(OUT_inReady), .IN_clear(IN_clear), .IN_ready(IN_ready),
        .OUT_valid(OUT_valid), .OUT_data(OUT_data), .OUT_count(OUT_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one bit for exactly one edge; returns 1 time unit after that edge.
    task automatic send_bit(input logic b);
        @(negedge clk);
        IN_valid = 1'b1;
        IN_bit   = b;
        @(posedge clk);
        #1;
        IN_valid = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    logic [7:0] w;
    logic [7:0] exp_w;
    logic [7:0] words [10];
    logic [7:0] q [$];
    logic       acc;
    int wi, bi, popped, cyc;

    initial begin
        rst = 1'b0; IN_valid = 1'b0; IN_bit = 1'b0; IN_clear = 1'b0; IN_ready = 1'b0;
        #2;
        chk("rst_valid", OUT_valid, 0);
        chk("rst_count", OUT_count, 0);
        chk("rst_data", OUT_data, 0);
        chk("rst_inready", OUT_inReady, 1);
        @(negedge clk);
        rst = 1'b1;

        // Single word: bits 1,0,1,1,0,0,0,1 LSB-first -> 8'h8D
        IN_ready = 1'b1;
        send_bit(1); send_bit(0); send_bit(1);
        chk("single_count3", OUT_count, 3);
        chk("single_novalid", OUT_valid, 0);
        send_bit(1); send_bit(0); send_bit(0); send_bit(0); send_bit(1);
        chk("single_valid", OUT_valid, 1);
        chk("single_data", OUT_data, 8'h8D);
        chk("single_count0", OUT_count, 0);
        @(posedge clk); #1;
        chk("single_onecycle", OUT_valid, 0);

        // Backpressure: FF and 00 fill the buffer, A5 stalls on its final bit
        IN_ready = 1'b0;
        send_word(8'hFF);
        send_word(8'h00);
        chk("bp_head", OUT_data, 8'hFF);
        w = 8'hA5;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        chk("bp_count7", OUT_count, 7);
        chk("bp_inready0", OUT_inReady, 0);
        @(negedge clk);
        IN_valid = 1'b1; IN_bit = w[7];
        #1;
        chk("bp_stall", OUT_inReady, 0);
        @(posedge clk); #1;
        chk("bp_notaccepted", OUT_count, 7);
        chk("bp_head_stable", OUT_data, 8'hFF);
        @(negedge clk);
        IN_ready = 1'b1;
        #1;
        chk("bp_release", OUT_inReady, 1);
        @(posedge clk); #1;
        IN_valid = 1'b0;
        chk("bp_pushpop_count", OUT_count, 0);
        chk("bp_pushpop_valid", OUT_valid, 1);
        chk("bp_order1", OUT_data, 8'h00);
        @(posedge clk); #1;
        chk("bp_order2", OUT_data, 8'hA5);
        chk("bp_order2_valid", OUT_valid, 1);
        @(posedge clk); #1;
        chk("bp_drained", OUT_valid, 0);

        // Clear after 5 bits drops the partial word and the offered bit
        IN_ready = 1'b0;
        send_word(8'h3C);
        for (int i = 0; i < 5; i++) send_bit(1);
        chk("clr_count5", OUT_count, 5);
        @(negedge clk);
        IN_valid = 1'b1; IN_bit = 1'b1; IN_clear = 1'b1;
        @(posedge clk); #1;
        IN_valid = 1'b0; IN_clear = 1'b0;
        chk("clr_count0", OUT_count, 0);
        chk("clr_buf_valid", OUT_valid, 1);
        chk("clr_buf_data", OUT_data, 8'h3C);
        send_word(8'h40);
        chk("clr_head", OUT_data, 8'h3C);
        @(negedge clk);
        IN_ready = 1'b1;
        @(posedge clk); #1;
        chk("clr_clean_word", OUT_data, 8'h40);
        @(posedge clk); #1;
        chk("clr_drained", OUT_valid, 0);

        // Async reset between edges with one buffered word and 4 bits in flight
        IN_ready = 1'b0;
        send_word(8'h5A);
        for (int i = 0; i < 4; i++) send_bit(1);
        chk("ar_pre_count", OUT_count, 4);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_valid", OUT_valid, 0);
        chk("ar_count", OUT_count, 0);
        chk("ar_data", OUT_data, 0);
        @(negedge clk);
        rst = 1'b1;
        IN_ready = 1'b1;
        send_word(8'hC3);
        chk("ar_after_valid", OUT_valid, 1);
        chk("ar_after_data", OUT_data, 8'hC3);
        @(posedge clk); #1;

        // Pointer wrap: 10 words against a reference queue with random IN_ready
        words = '{8'h01, 8'h80, 8'h7E, 8'hC4, 8'h3B, 8'hF0, 8'h0F, 8'h96, 8'h55, 8'hE1};
        wi = 0; bi = 0; popped = 0; cyc = 0;
        while (popped < 10 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            IN_ready = 1'($urandom_range(0, 1));
            IN_valid = (wi < 10);
            w        = (wi < 10) ? words[wi] : 8'h00;
            IN_bit   = w[bi];
            #1;
            acc = IN_valid && OUT_inReady;
            if (OUT_valid && IN_ready) begin
                if (q.size() == 0) begin
                    chk("wrap_spurious", 1, 0);
                end else begin
                    exp_w = q.pop_front();
                    chk("wrap_data", OUT_data, exp_w);
                end
                popped++;
            end
            @(posedge clk);
            if (acc) begin
                if (bi == 7) begin
                    q.push_back(words[wi]);
                    wi++;
                    bi = 0;
                end else begin
                    bi++;
                end
            end
        end
        IN_valid = 1'b0;
        chk("wrap_all_popped", popped, 10);
        #1;
        chk("wrap_empty", OUT_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
